// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: drives stage enables/clears, PC enable and redirect.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_req_w,
    input  logic                 ex_mispredict,
    input  logic                 mem_req_multi,
    input  logic                 dm_ready,
    input  logic                 wb_halt,
    output logic                 en_pc,
    output logic                 en_ps1,
    output logic                 en_ps2,
    output logic                 en_ps3,
    output logic                 en_ps4,
    output logic                 clear_ps1,
    output logic                 clear_ps2,
    output logic                 clear_ps3,
    output logic                 clear_ps4,
    output logic                 pc_redirect,
    output logic                 halted,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] wait_cnt_reg;
    logic [15:0] wait_cnt_next;
    logic        halted_reg;
    logic        mem_err_reg;
    logic        err_set;

    // Index 0 is the PC, 1..4 are the stage registers PS1..PS4.
    logic [4:0]  en_vec;
    logic [4:1]  clear_vec;
    logic        redirect;
    logic        hz;
    logic        frozen;
    logic        resolve;

    assign hz = ex_mem_read && (ex_req_w != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_req_w)) ||
                 (id_uses_rt && (id_rt == ex_req_w)));

    always_comb begin
        en_vec        = '1;
        clear_vec     = '0;
        redirect      = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        err_set       = 1'b0;
        frozen        = 1'b0;
        resolve       = 1'b0;

        if (rst) begin
            en_vec    = '0;
            clear_vec = '1;
        end else begin
            unique case (state_reg)
                RUN: begin
                    if (!wb_halt && mem_req_multi && !dm_ready) begin
                        frozen        = 1'b1;
                        state_next    = MEM_WAIT;
                        wait_cnt_next = 16'd1;
                    end else begin
                        resolve = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!dm_ready) begin
                        frozen = 1'b1;
                        if (wait_cnt_reg == TIMEOUT_VAL) begin
                            err_set    = 1'b1;
                            state_next = HALT;
                        end else begin
                            wait_cnt_next = wait_cnt_reg + 16'd1;
                        end
                    end else begin
                        resolve    = 1'b1;
                        state_next = RUN;
                    end
                end
                HALT: begin
                    en_vec = '0;
                end
                default: begin
                    en_vec     = '0;
                    state_next = HALT;
                end
            endcase

            // Held EX/ID contents are only judged once the memory freeze lifts.
            if (frozen) begin
                en_vec[3:0]  = 4'b0000;
                clear_vec[4] = 1'b1;
            end else if (resolve) begin
                if (wb_halt) begin
                    en_vec     = '0;
                    state_next = HALT;
                end else if (ex_mispredict) begin
                    clear_vec[1] = 1'b1;
                    clear_vec[2] = 1'b1;
                    redirect     = 1'b1;
                end else if (hz) begin
                    en_vec[0]    = 1'b0;
                    en_vec[1]    = 1'b0;
                    clear_vec[2] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 16'd0;
            halted_reg   <= 1'b0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= (state_next == MEM_WAIT) ? wait_cnt_next : 16'd0;
            halted_reg   <= (state_next == HALT);
            mem_err_reg  <= mem_err_reg | err_set;
        end
    end

    assign en_pc       = en_vec[0];
    assign en_ps1      = en_vec[1];
    assign en_ps2      = en_vec[2];
    assign en_ps3      = en_vec[3];
    assign en_ps4      = en_vec[4];
    assign clear_ps1   = clear_vec[1];
    assign clear_ps2   = clear_vec[2];
    assign clear_ps3   = clear_vec[3];
    assign clear_ps4   = clear_vec[4];
    assign pc_redirect = redirect;
    assign halted      = halted_reg;
    assign mem_err     = mem_err_reg;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_reg;
    logic [CNT_WIDTH-1:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!en_vec[0] && (state_reg != HALT))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (redirect)
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the four pipeline stage registers: PS1 IF/ID, PS2 ID/EX, PS3 EX/MEM, PS4 MEM/WB.
- Drives every stage's en/clear and the PC enable.
- Resolves load-use stalls, branch-mispredict flushes, multi-cycle data-memory waits and syscall halt.
- Holds the run/wait/halt state machine so the stage registers stay pure storage.

Parameters:
MEM_TIMEOUT, 255, max cycles in MEM_WAIT before error halt (1..2^16-1)
CNT_WIDTH, 32, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
id_rs  in  5  rs field of instruction in ID (PS1 output)
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  instruction in EX (PS2 output) is a load
ex_req_w  in  5  destination register of EX instruction
ex_mispredict  in  1  EX branch resolved, target != pc_guessed
mem_req_multi  in  1  MEM instruction issues multi-cycle datamem access
dm_ready  in  1  datamem access complete this cycle
wb_halt  in  1  syscall_en in WB with exit service
en_pc  out  1  PC register load enable
en_ps1..en_ps4  out  1 each  stage register enables
clear_ps1..clear_ps4  out  1 each  stage register synchronous clears (override en)
pc_redirect  out  1  select EX-resolved target into PC
halted  out  1  core halted
mem_err  out  1  sticky datamem timeout flag
stall_cnt, flush_cnt  out  CNT_WIDTH each  performance counters (see Optional Feature)

Behaviour:
- Clock clk. Reset rst is synchronous and active-high.
- States: RUN, MEM_WAIT, HALT. Encoded 2 bits. Reset -> RUN.
- Reset/register values: wait_cnt=0, halted=0, mem_err=0, counters=0.
- While rst=1, outputs are forced: all en_*=0, all clear_*=1, pc_redirect=0.
- en/clear/pc_redirect are combinational from state and inputs (zero latency). halted and mem_err are registered.
- Load-use hazard is computed as: hz = ex_mem_read & (ex_req_w!=0) & ((id_uses_rs & id_rs==ex_req_w) | (id_uses_rt & id_rt==ex_req_w)).
- RUN priority, highest first. Default for all cases not listed: all en=1, all clear=0.
  1. wb_halt: all en=0, no clears; next state HALT; halted=1 from next cycle.
  2. mem_req_multi & !dm_ready: en_pc/en_ps1/en_ps2/en_ps3=0, clear_ps4=1 (bubble to WB); next state MEM_WAIT, wait_cnt<=1.
  3. ex_mispredict: all en=1, clear_ps1=1, clear_ps2=1, pc_redirect=1. Mispredict overrides hz (ID instruction is wrong-path).
  4. hz: en_pc=0, en_ps1=0, clear_ps2=1 (bubble into EX), en_ps3=en_ps4=1.
- mem_req_multi & dm_ready in the same cycle is a single-cycle access: no wait.
- MEM_WAIT:
  - dm_ready=1: behave as RUN priorities 1, 3 and 4 using current inputs; next state RUN (or HALT per rule 1).
  - dm_ready=0: same freeze as rule 2; wait_cnt++.
  - wait_cnt==MEM_TIMEOUT with dm_ready=0: mem_err<=1, next state HALT.
  - A mispredict/hz asserted while frozen is not acted on; it is re-evaluated when released, since EX is held.
- HALT: all en=0, no clears, pc_redirect=0. Exits only via rst.
- rst asserted in any state returns to RUN next cycle; an in-progress wait is abandoned.

Optional Feature:
PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each non-reset cycle with en_pc=0 outside HALT.
  - flush_cnt increments each cycle pc_redirect=1.
  - Both wrap at 2^CNT_WIDTH. Both clear on rst.
- Undefined: both counters tied to 0, no counter flops.

Test Plan:
- Load-use: ex_mem_read=1, ex_req_w=8, id_rs=8, id_uses_rs=1 -> en_pc=0, en_ps1=0, clear_ps2=1, en_ps3=1 for one cycle. With ex_req_w=0 -> no stall.
- Mispredict+hz same cycle: ex_mispredict=1 and hz true -> clear_ps1=clear_ps2=1, pc_redirect=1, en_pc=1, no stall.
- Multi-cycle mem: mem_req_multi=1, dm_ready low 3 cycles -> 3 cycles of freeze with clear_ps4=1; 4th cycle dm_ready=1 -> all en=1; state RUN.
- Timeout, MEM_TIMEOUT=4, dm_ready never asserted -> mem_err=1 and halted=1 after 4th wait cycle. Outputs frozen until rst.
- Halt: wb_halt=1 -> all en=0 that cycle; halted=1 next cycle. Later ex_mispredict ignored. rst=1 one cycle -> RUN, halted=0.
- PIPE_PERF_CNT_EN: run load-use ×2 plus mispredict ×1 -> stall_cnt=2, flush_cnt=1. Undefined build -> both read 0.
